// File: rtl/shot_sfx_if.sv
// Control and sample bundle between the game logic and the shot sound
// generator: trigger and volume in, audio sample and busy flag out.
interface shot_sfx_if;
  logic               trigger;
  logic [3:0]         vol_num;
  logic signed [15:0] audio;
  logic               busy;

  // Game-logic / bench side drives the request and volume.
  modport master (
    output trigger,
    output vol_num,
    input  audio,
    input  busy
  );

  // Generator side consumes the request and produces the sample.
  modport slave (
    input  trigger,
    input  vol_num,
    output audio,
    output busy
  );
endinterface

// File: rtl/shot_sfx_gen.sv
// Triggered "pew" generator: a square wave whose half-period grows and whose
// amplitude halves at each segment boundary. The trigger is resynchronised
// and edge-detected, so a held trigger yields one sound and a fresh rising
// edge during playback restarts the sound from segment 0.
module shot_sfx_gen #(
  parameter int START_HALF = 50000,
  parameter int SWEEP_STEP = 2000,
  parameter int SEG_LEN    = 1250000,
  parameter int NUM_SEGS   = 8
) (
  input  logic     clk,
  input  logic     rst,
  shot_sfx_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam logic [21:0] START_HALF_V = 22'(START_HALF);
  localparam logic [22:0] SWEEP_STEP_V = 23'(SWEEP_STEP);
  localparam logic [23:0] SEG_LAST     = 24'(SEG_LEN - 1);
  localparam logic [2:0]  LAST_SEG     = 3'(NUM_SEGS - 1);

  // Trigger resynchroniser and edge detector
  logic sync1, sync2, prev;
  logic start;

  state_t       state_reg, state_next;
  logic [2:0]   seg_idx_reg, seg_idx_next;
  logic [21:0]  cur_half_reg, cur_half_next;
  logic [21:0]  hc_reg, hc_next;
  logic [23:0]  sc_reg, sc_next;
  logic         phase_reg, phase_next;
  logic [15:0]  audio_reg, audio_next;
  logic         busy_reg, busy_next;

  logic [15:0]  base_amp;
  logic [15:0]  amp;
  logic [22:0]  half_sum;

  assign start     = sync2 & ~prev;
  assign bus.audio = audio_reg;
  assign bus.busy  = busy_reg;

  // Two-flop synchroniser plus previous-value flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.trigger;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FSM state, waveform counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      seg_idx_reg  <= 3'd0;
      cur_half_reg <= 22'd0;
      hc_reg       <= 22'd0;
      sc_reg       <= 24'd0;
      phase_reg    <= 1'b0;
      audio_reg    <= 16'h0000;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      seg_idx_reg  <= seg_idx_next;
      cur_half_reg <= cur_half_next;
      hc_reg       <= hc_next;
      sc_reg       <= sc_next;
      phase_reg    <= phase_next;
      audio_reg    <= audio_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic: start/restart, half-period toggling, segment sweep
  always_comb begin
    state_next    = state_reg;
    seg_idx_next  = seg_idx_reg;
    cur_half_next = cur_half_reg;
    hc_next       = hc_reg;
    sc_next       = sc_reg;
    phase_next    = phase_reg;
    half_sum      = {1'b0, cur_half_reg} + SWEEP_STEP_V;

    if (start) begin
      // Same initialisation from IDLE and on retrigger during PLAY.
      state_next    = PLAY;
      seg_idx_next  = 3'd0;
      cur_half_next = START_HALF_V;
      hc_next       = 22'd0;
      sc_next       = 24'd0;
      phase_next    = 1'b1;
    end else if (state_reg == PLAY) begin
      // ">=" keeps the counter bounded even if cur_half ever shrank.
      if (hc_reg >= cur_half_reg - 22'd1) begin
        hc_next    = 22'd0;
        phase_next = ~phase_reg;
      end else begin
        hc_next = hc_reg + 22'd1;
      end

      if (sc_reg == SEG_LAST) begin
        sc_next = 24'd0;
        if (seg_idx_reg == LAST_SEG) begin
          state_next = IDLE;
        end else begin
          seg_idx_next  = seg_idx_reg + 3'd1;
          cur_half_next = half_sum[22] ? 22'h3FFFFF : half_sum[21:0];
        end
      end else begin
        sc_next = sc_reg + 24'd1;
      end
    end
  end

  // Base amplitude from the live volume setting; out-of-range means mute
  always_comb begin
    base_amp = 16'h0000;
    case (bus.vol_num)
      4'd1:    base_amp = 16'h0400;
      4'd2:    base_amp = 16'h0800;
      4'd3:    base_amp = 16'h1000;
      4'd4:    base_amp = 16'h2000;
      4'd5:    base_amp = 16'h3FFF;
      default: base_amp = 16'h0000;
    endcase
  end

  // Output sample built from the post-edge phase/segment so it lines up with busy
  always_comb begin
    amp        = base_amp >> seg_idx_next;
    audio_next = 16'h0000;
    busy_next  = 1'b0;
    if (state_next == PLAY) begin
      busy_next  = 1'b1;
      audio_next = phase_next ? amp : (16'h0000 - amp);
    end
  end

endmodule

// File: tb/tb_shot_sfx_gen.sv
// Scoreboard bench for shot_sfx_gen. The driver applies one set of inputs per
// clock, advances a behavioural model of the sound and queues the expected
// busy/audio pair; the monitor pops and compares on every falling edge.
module tb_shot_sfx_gen;

  localparam int SH  = 4;
  localparam int SS  = 2;
  localparam int SL  = 32;
  localparam int NS  = 4;
  localparam int LEN = SL * NS;

  typedef struct {
    logic        busy;
    logic [15:0] audio;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shot_sfx_if bus();

  shot_sfx_gen #(
    .START_HALF(SH),
    .SWEEP_STEP(SS),
    .SEG_LEN(SL),
    .NUM_SEGS(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_no = 0;

  // Model state
  bit   ph_tab[LEN];
  bit   h1, h2, h3;
  bit   m_play;
  int   m_n;
  int   busy_rises;
  logic last_busy;

  function automatic logic [15:0] base_of(input logic [3:0] v);
    case (v)
      4'd1:    return 16'h0400;
      4'd2:    return 16'h0800;
      4'd3:    return 16'h1000;
      4'd4:    return 16'h2000;
      4'd5:    return 16'h3FFF;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected phase of every sample of a sound: half-period of sample i is
  // SH + SS * (segment of sample i).
  task automatic build_phase_table();
    bit ph = 1'b1;
    int cnt = 0;
    for (int i = 0; i < LEN; i++) begin
      int half;
      ph_tab[i] = ph;
      half = SH + SS * (i / SL);
      if (cnt == half - 1) begin
        ph  = ~ph;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  endtask

  // One clock: advance model with the inputs present at this edge, queue expectation
  task automatic tick();
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    edge_no++;
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_play = 0;
      m_n = 0;
    end else begin
      st = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = bus.trigger;
      if (st) begin
        m_play = 1;
        m_n = 0;
      end else if (m_play) begin
        if (m_n == LEN - 1) m_play = 0;
        else m_n++;
      end
    end
    e.idx   = edge_no;
    e.busy  = m_play;
    e.audio = 16'h0000;
    if (m_play) begin
      logic [15:0] a;
      a = base_of(bus.vol_num) >> (m_n / SL);
      e.audio = ph_tab[m_n] ? a : (16'h0000 - a);
    end
    q.push_back(e);
    if (bus.busy === 1'b1 && last_busy !== 1'b1) busy_rises++;
    last_busy = bus.busy;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset applied between edges, checked before the next edge
  task automatic async_reset(input int hold);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.audio !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_immediate: busy=%b audio=%h, need busy=0 audio=0000",
               bus.busy, bus.audio);
    end
    ticks(hold);
    rst = 1'b0;
  endtask

  // Monitor: compares every presented sample against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (bus.busy !== e.busy || bus.audio !== e.audio) begin
          n_fail++;
          $display("FAIL sample_edge%0d: busy=%b audio=%h, need busy=%b audio=%h",
                   e.idx, bus.busy, bus.audio, e.busy, e.audio);
        end else begin
          $display("[TB] edge %0d busy=%b audio=%h ok", e.idx, bus.busy, bus.audio);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bus.trigger = 1'b0;
    bus.vol_num = 4'd3;
    h1 = 0; h2 = 0; h3 = 0;
    m_play = 0;
    m_n = 0;
    busy_rises = 0;
    last_busy = 1'b0;
    build_phase_table();

    // Reset held for 5 cycles, outputs stay quiet after release
    ticks(5);
    rst = 1'b0;
    ticks(6);

    // Single shot at volume 3, full 128-cycle sound
    bus.trigger = 1'b1;
    ticks(10);
    bus.trigger = 1'b0;
    ticks(LEN + 10);

    // Volume change during segment 1, then mute, then restore
    bus.trigger = 1'b1;
    ticks(4);
    bus.trigger = 1'b0;
    ticks(36);
    bus.vol_num = 4'd5;
    ticks(8);
    bus.vol_num = 4'd0;
    ticks(6);
    bus.vol_num = 4'd9;
    ticks(3);
    bus.vol_num = 4'd3;
    ticks(LEN);

    // Retrigger 50 cycles into a sound
    bus.trigger = 1'b1;
    ticks(5);
    bus.trigger = 1'b0;
    ticks(45);
    bus.trigger = 1'b1;
    ticks(5);
    bus.trigger = 1'b0;
    ticks(LEN + 10);

    // Held trigger: exactly one sound
    busy_rises = 0;
    bus.trigger = 1'b1;
    ticks(1000);
    bus.trigger = 1'b0;
    ticks(5);
    n_tests++;
    if (busy_rises != 1) begin
      n_fail++;
      $display("FAIL held_trigger_sounds: got %0d busy pulses, need 1", busy_rises);
    end

    // Trigger held across reset release starts one sound
    rst = 1'b1;
    bus.trigger = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(6);
    bus.trigger = 1'b0;
    ticks(LEN);

    // Mid-sound reset: silence immediately and nothing afterwards
    bus.trigger = 1'b1;
    ticks(4);
    bus.trigger = 1'b0;
    ticks(38);
    async_reset(3);
    ticks(LEN + 10);

    // Drain scoreboard
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
